// File: rtl/rom_boot_loader_pkg.sv
// Shared types and constants for the ROM boot loader.
package rom_boot_loader_pkg;

   localparam int         ROM_WORDS         = 1024;
   localparam int         ROM_AW            = 10;
   localparam int         CNT_W             = ROM_AW + 1;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_WRITE,
      S_CSUM
   } state_t;

   // A frame must carry at least one word and no more than the ROM holds.
   function automatic logic count_ok(input logic [15:0] cnt);
      return (cnt != 16'd0) && (cnt <= 16'(ROM_WORDS));
   endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Byte-stream receive handshake plus the ROM debug-access write port.
interface rom_boot_loader_if;
   import rom_boot_loader_pkg::*;

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [ROM_AW-1:0] rom_address;
   logic [31:0]       rom_writedata;
   logic [3:0]        rom_byteenable;
   logic              rom_chipselect;
   logic              rom_write;
   logic              rom_debugaccess;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, rom_address, rom_writedata, rom_byteenable,
             rom_chipselect, rom_write, rom_debugaccess
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, rom_address, rom_writedata, rom_byteenable,
             rom_chipselect, rom_write, rom_debugaccess
   );

endinterface

// File: rtl/rom_boot_timeout.sv
// Inter-byte watchdog: loadable down-counter, expired once it has run down to zero.
module rom_boot_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= LOAD_VAL;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (en && (count != '0)) begin
         count <= count - TW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/rom_boot_loader.sv
// Framed byte-stream loader into the program ROM; holds the CPU in reset while loading.
// Optional trailing checksum byte enabled by defining ROM_BOOT_LOADER_CHECKSUM_EN.
//
// state   | meaning
// S_IDLE  | waiting for sync byte, other bytes dropped
// S_HDR   | collecting ADDR_HI, ADDR_LO, CNT_HI, CNT_LO
// S_DATA  | collecting 4 payload bytes of the next word
// S_WRITE | single-cycle ROM write strobe, rx stalled
// S_CSUM  | waiting for the checksum byte
module rom_boot_loader
   import rom_boot_loader_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   rom_boot_loader_if.master bus,
   output logic              cpu_reset_req,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               sync_start;
   logic               expired;
   logic               done_nxt;
   logic               error_nxt;
   logic [1:0]         idx;
   logic [31:0]        word;
   logic [ROM_AW-1:0]  addr;
   logic [CNT_W-1:0]   remaining;
   logic [15:0]        cnt_hdr;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
   logic [7:0]         sum;
   logic [7:0]         sum_chk;
   assign sum_chk = sum + bus.rx_data;
`endif

   assign bus.rx_ready        = (state != S_WRITE);
   assign bus.rom_address     = addr;
   assign bus.rom_writedata   = word;
   assign bus.rom_byteenable  = 4'hF;
   assign bus.rom_write       = (state == S_WRITE);
   assign bus.rom_chipselect  = (state == S_WRITE);
   assign bus.rom_debugaccess = (state == S_WRITE);

   assign accept     = bus.rx_valid & bus.rx_ready;
   assign sync_start = (state == S_IDLE) && accept && (bus.rx_data == SYNC_BYTE);
   // Header bytes shift through the word register; CNT_HI sits in the top byte when CNT_LO arrives.
   assign cnt_hdr    = {word[31:24], bus.rx_data};

   rom_boot_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept || (state == S_IDLE)),
      .en      (state != S_IDLE),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      error_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            if (sync_start) state_nxt = S_HDR;
         end
         S_HDR: begin
            if (accept) begin
               if (idx == 2'd3) begin
                  if (count_ok(cnt_hdr)) begin
                     state_nxt = S_DATA;
                  end else begin
                     state_nxt = S_IDLE;
                     error_nxt = 1'b1;
                  end
               end
            end else if (expired) begin
               state_nxt = S_IDLE;
               error_nxt = 1'b1;
            end
         end
         S_DATA: begin
            if (accept) begin
               if (idx == 2'd3) state_nxt = S_WRITE;
            end else if (expired) begin
               state_nxt = S_IDLE;
               error_nxt = 1'b1;
            end
         end
         S_WRITE: begin
            if (remaining == CNT_W'(1)) begin
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
               state_nxt = S_CSUM;
`else
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
`endif
            end else begin
               state_nxt = S_DATA;
            end
         end
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) begin
               state_nxt = S_IDLE;
               if (sum_chk == 8'h00) done_nxt = 1'b1;
               else                  error_nxt = 1'b1;
            end else if (expired) begin
               state_nxt = S_IDLE;
               error_nxt = 1'b1;
            end
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cpu_reset_req <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         idx           <= '0;
         word          <= '0;
         addr          <= '0;
         remaining     <= '0;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
         sum           <= '0;
`endif
      end else begin
         done  <= done_nxt;
         error <= error_nxt;
         busy  <= (state_nxt != S_IDLE);
         // Only a successful frame releases the CPU; aborts leave it held.
         if (sync_start)    cpu_reset_req <= 1'b1;
         else if (done_nxt) cpu_reset_req <= 1'b0;

         if (sync_start) begin
            idx <= '0;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
            sum <= '0;
`endif
         end else if (accept && ((state == S_HDR) || (state == S_DATA))) begin
            word <= {bus.rx_data, word[31:8]};
            idx  <= idx + 2'd1;
`ifdef ROM_BOOT_LOADER_CHECKSUM_EN
            sum  <= sum_chk;
`endif
         end

         if (accept && (state == S_HDR) && (idx == 2'd3)) begin
            addr      <= {word[9:8], word[23:16]};
            remaining <= cnt_hdr[CNT_W-1:0];
         end

         if (state == S_WRITE) begin
            addr      <= addr + ROM_AW'(1);
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

endmodule
